lbist_counter: RTL and testbench

- Parameterised up-counter used in the LBIST controller to count applied test patterns / clock cycles.
- Increments by one on each rising `clk` edge where the `inc` enable is sampled high.
- Exposes the count value, a terminal-count flag and a one-cycle wrap pulse to the BIST sequencer.

---
 rtl/lbist_counter.sv | 70 +++++++
 tb/tb_lbist_counter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lbist_counter.sv
// LBIST pattern/cycle up-counter with terminal-count decode and wrap pulse.
// Optional build macro COUNTER_SATURATE_EN: hold at MAX_COUNT instead of wrapping (wrap tied low).
module lbist_counter #(
    parameter int unsigned     BITS      = 8,
    parameter logic [BITS-1:0] MAX_COUNT = {BITS{1'b1}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [BITS-1:0] counter,
    output logic            tc,
    output logic            wrap
);

    logic            at_max;
    logic [BITS-1:0] counter_nxt;

    // Compare is on the BITS-wide register only; no adder carry-out is used.
    assign at_max = (counter == MAX_COUNT);
    assign tc     = at_max;

`ifdef COUNTER_SATURATE_EN

    always_comb begin
        counter_nxt = counter;
        if (inc && !at_max) begin
            counter_nxt = counter + BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= '0;
        end else begin
            counter <= counter_nxt;
        end
    end

    assign wrap = 1'b0;

`else

    logic wrap_nxt;

    always_comb begin
        counter_nxt = counter;
        wrap_nxt    = 1'b0;
        if (inc) begin
            if (at_max) begin
                counter_nxt = '0;
                wrap_nxt    = 1'b1;
            end else begin
                counter_nxt = counter + BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= '0;
            wrap    <= 1'b0;
        end else begin
            counter <= counter_nxt;
            wrap    <= wrap_nxt;
        end
    end

`endif

endmodule

// File: tb/tb_lbist_counter.sv
// Self-checking bench for lbist_counter: default 8-bit instance and a BITS=4/MAX_COUNT=9 instance.
// Reference model counts increments with plain modular arithmetic (saturating if COUNTER_SATURATE_EN).
module tb_lbist_counter;

    localparam int MAX8 = 255;
    localparam int MAX4 = 9;

    logic       clk;
    logic       rst;
    logic       inc8;
    logic       inc4;
    logic [7:0] counter8;
    logic       tc8;
    logic       wrap8;
    logic [3:0] counter4;
    logic       tc4;
    logic       wrap4;

    int checks;
    int errors;

    // reference model state
    int m8;
    int m4;
    bit mw8;
    bit mw4;

    lbist_counter dut8 (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc8),
        .counter (counter8),
        .tc      (tc8),
        .wrap    (wrap8)
    );

    lbist_counter #(
        .BITS      (4),
        .MAX_COUNT (4'd9)
    ) dut4 (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc4),
        .counter (counter4),
        .tc      (tc4),
        .wrap    (wrap4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int next_count(input int cur, input int max);
`ifdef COUNTER_SATURATE_EN
        return (cur < max) ? cur + 1 : max;
`else
        return (cur + 1) % (max + 1);
`endif
    endfunction

    function automatic bit wrapped(input int cur, input int max);
`ifdef COUNTER_SATURATE_EN
        return 1'b0;
`else
        return cur == max;
`endif
    endfunction

    task automatic model_reset();
        m8  = 0;
        m4  = 0;
        mw8 = 1'b0;
        mw4 = 1'b0;
    endtask

    // Advance one rising edge, update the model, and leave time at edge + 1.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mw8 = inc8 && wrapped(m8, MAX8);
            mw4 = inc4 && wrapped(m4, MAX4);
            if (inc8) m8 = next_count(m8, MAX8);
            if (inc4) m4 = next_count(m4, MAX4);
        end else begin
            model_reset();
        end
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        inc8 = 1'b1;
        inc4 = 1'b1;
        model_reset();
        #1;
        checks++; if (counter8 !== 8'd0 || tc8 !== 1'b0 || wrap8 !== 1'b0) begin errors++; $display("FAIL reset_initial8 got cnt=%0d tc=%b wrap=%b exp 0/0/0", counter8, tc8, wrap8); end
        checks++; if (counter4 !== 4'd0 || tc4 !== 1'b0 || wrap4 !== 1'b0) begin errors++; $display("FAIL reset_initial4 got cnt=%0d tc=%b wrap=%b exp 0/0/0", counter4, tc4, wrap4); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (counter8 !== 8'd0 || tc8 !== 1'b0 || wrap8 !== 1'b0) begin errors++; $display("FAIL reset_hold8 cyc %0d got cnt=%0d tc=%b wrap=%b exp 0/0/0", i, counter8, tc8, wrap8); end
            checks++; if (counter4 !== 4'd0 || tc4 !== 1'b0 || wrap4 !== 1'b0) begin errors++; $display("FAIL reset_hold4 cyc %0d got cnt=%0d tc=%b wrap=%b exp 0/0/0", i, counter4, tc4, wrap4); end
        end
        #2 rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (counter8 !== 8'(i) || counter8 !== 8'(m8)) begin errors++; $display("FAIL release_count8 got %0d exp %0d", counter8, i); end
            checks++; if (counter4 !== 4'(i) || counter4 !== 4'(m4)) begin errors++; $display("FAIL release_count4 got %0d exp %0d", counter4, i); end
        end
    endtask

    task automatic test_wrap();
        int wrap_seen;
        wrap_seen = 0;
        inc8 = 1'b1;
        inc4 = 1'b0;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (wrap8 === 1'b1) wrap_seen++;
            checks++; if (counter8 !== 8'(m8) || tc8 !== (m8 == MAX8) || wrap8 !== mw8) begin
                errors++; $display("FAIL wrap8 edge %0d got cnt=%0d tc=%b wrap=%b exp cnt=%0d tc=%b wrap=%b", i, counter8, tc8, wrap8, m8, (m8 == MAX8), mw8);
            end
        end
`ifdef COUNTER_SATURATE_EN
        checks++; if (wrap_seen != 0 || counter8 !== 8'd255 || tc8 !== 1'b1) begin errors++; $display("FAIL saturate8 got cnt=%0d tc=%b wraps=%0d exp 255/1/0", counter8, tc8, wrap_seen); end
`else
        checks++; if (wrap_seen != 1) begin errors++; $display("FAIL wrap8_pulses got %0d exp 1", wrap_seen); end
`endif
    endtask

    task automatic test_toggle();
        int exp_tab [10];
        exp_tab = '{1, 2, 3, 3, 3, 3, 3, 3, 4, 5};
        rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inc8 = (i < 3 || i >= 8);
            inc4 = inc8;
            tick();
            checks++; if (counter8 !== 8'(exp_tab[i]) || wrap8 !== 1'b0) begin errors++; $display("FAIL toggle8 step %0d got cnt=%0d wrap=%b exp %0d/0", i, counter8, wrap8, exp_tab[i]); end
            checks++; if (counter4 !== 4'(exp_tab[i]) || wrap4 !== 1'b0) begin errors++; $display("FAIL toggle4 step %0d got cnt=%0d wrap=%b exp %0d/0", i, counter4, wrap4, exp_tab[i]); end
        end
    endtask

    task automatic test_async_reset();
        rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        inc8 = 1'b1;
        inc4 = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        checks++; if (counter8 !== 8'd100 || counter4 !== 4'(m4) || wrap4 !== mw4) begin
            errors++; $display("FAIL count_to_100 got cnt8=%0d cnt4=%0d wrap4=%b exp 100/%0d/%b", counter8, counter4, wrap4, m4, mw4);
        end
        // drop reset mid-cycle: clears immediately, cancelling the pending wrap4 pulse
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++; if (counter8 !== 8'd0 || tc8 !== 1'b0 || wrap8 !== 1'b0) begin errors++; $display("FAIL async_clear8 got cnt=%0d tc=%b wrap=%b exp 0/0/0", counter8, tc8, wrap8); end
        checks++; if (counter4 !== 4'd0 || tc4 !== 1'b0 || wrap4 !== 1'b0) begin errors++; $display("FAIL async_clear4 got cnt=%0d tc=%b wrap=%b exp 0/0/0", counter4, tc4, wrap4); end
        tick();
        checks++; if (counter8 !== 8'd0 || counter4 !== 4'd0) begin errors++; $display("FAIL reset_ignores_clk got cnt8=%0d cnt4=%0d exp 0/0", counter8, counter4); end
        #2 rst = 1'b1;
        tick();
        checks++; if (counter8 !== 8'd1 || counter4 !== 4'd1) begin errors++; $display("FAIL resume_after_reset got cnt8=%0d cnt4=%0d exp 1/1", counter8, counter4); end
    endtask

    task automatic test_mod9();
        int tc_seen;
        int wrap_seen;
        tc_seen   = 0;
        wrap_seen = 0;
        rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        inc8 = 1'b0;
        inc4 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tc4 === 1'b1) tc_seen++;
            if (wrap4 === 1'b1) wrap_seen++;
            checks++; if (counter4 !== 4'(m4) || tc4 !== (m4 == MAX4) || wrap4 !== mw4) begin
                errors++; $display("FAIL mod9 edge %0d got cnt=%0d tc=%b wrap=%b exp cnt=%0d tc=%b wrap=%b", i, counter4, tc4, wrap4, m4, (m4 == MAX4), mw4);
            end
        end
`ifdef COUNTER_SATURATE_EN
        checks++; if (wrap_seen != 0 || tc_seen != 4) begin errors++; $display("FAIL mod9_flags got tc=%0d wrap=%0d exp 4/0", tc_seen, wrap_seen); end
`else
        checks++; if (wrap_seen != 1 || tc_seen != 1) begin errors++; $display("FAIL mod9_flags got tc=%0d wrap=%0d exp 1/1", tc_seen, wrap_seen); end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            inc8 = 1'($urandom_range(0, 3) != 0);
            inc4 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 79) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                #1;
                checks++; if (counter8 !== 8'd0 || wrap8 !== 1'b0 || counter4 !== 4'd0 || wrap4 !== 1'b0) begin
                    errors++; $display("FAIL random_reset got cnt8=%0d wrap8=%b cnt4=%0d wrap4=%b exp all 0", counter8, wrap8, counter4, wrap4);
                end
                #1 rst = 1'b1;
            end
            tick();
            checks++; if (counter8 !== 8'(m8) || tc8 !== (m8 == MAX8) || wrap8 !== mw8) begin
                errors++; $display("FAIL random8 cyc %0d got cnt=%0d tc=%b wrap=%b exp cnt=%0d tc=%b wrap=%b", i, counter8, tc8, wrap8, m8, (m8 == MAX8), mw8);
            end
            checks++; if (counter4 !== 4'(m4) || tc4 !== (m4 == MAX4) || wrap4 !== mw4) begin
                errors++; $display("FAIL random4 cyc %0d got cnt=%0d tc=%b wrap=%b exp cnt=%0d tc=%b wrap=%b", i, counter4, tc4, wrap4, m4, (m4 == MAX4), mw4);
            end
        end
    endtask

    task automatic test_saturate_hold();
        // keep incrementing 265 edges from 0: wraps (default) or sticks at 255 (saturating)
        rst = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        inc8 = 1'b1;
        inc4 = 1'b1;
        for (int i = 0; i < 265; i++) begin
            tick();
            checks++; if (counter8 !== 8'(m8) || tc8 !== (m8 == MAX8) || wrap8 !== mw8) begin
                errors++; $display("FAIL hold8 edge %0d got cnt=%0d tc=%b wrap=%b exp cnt=%0d tc=%b wrap=%b", i, counter8, tc8, wrap8, m8, (m8 == MAX8), mw8);
            end
        end
`ifdef COUNTER_SATURATE_EN
        checks++; if (counter8 !== 8'd255 || tc8 !== 1'b1 || wrap8 !== 1'b0) begin errors++; $display("FAIL saturate_end got cnt=%0d tc=%b wrap=%b exp 255/1/0", counter8, tc8, wrap8); end
`else
        checks++; if (counter8 !== 8'd9 || tc8 !== 1'b0) begin errors++; $display("FAIL wrap_end got cnt=%0d tc=%b exp 9/0", counter8, tc8); end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        inc8   = 1'b0;
        inc4   = 1'b0;
        model_reset();
        test_reset();
        test_wrap();
        test_toggle();
        test_async_reset();
        test_mod9();
        test_saturate_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
